// File: rtl/cfg_rd_arbiter_if.sv
// Shared configuration read port bundle: requester-side request/lock/address
// inputs, the issued grant, the memory read strobe/address, and the
// read-data valid and lock-holder indications.
interface cfg_rd_arbiter_if #(
  parameter int NUM_REQ            = 4,
  parameter int NURN_CNT_BIT_WIDTH = 8
);
  logic [NUM_REQ-1:0]                    req_i;
  logic [NUM_REQ-1:0]                    lock_i;
  logic [NUM_REQ*NURN_CNT_BIT_WIDTH-1:0] addr_i;
  logic [NUM_REQ-1:0]                    gnt_o;
  logic                                  rdEn_Config_o;
  logic [NURN_CNT_BIT_WIDTH-1:0]         Addr_Config_o;
  logic [NUM_REQ-1:0]                    rdVld_o;
  logic [NUM_REQ-1:0]                    lockOwner_o;

  // requester / environment side
  modport master (
    output req_i, lock_i, addr_i,
    input  gnt_o, rdEn_Config_o, Addr_Config_o, rdVld_o, lockOwner_o
  );

  // arbiter side
  modport slave (
    input  req_i, lock_i, addr_i,
    output gnt_o, rdEn_Config_o, Addr_Config_o, rdVld_o, lockOwner_o
  );
endinterface

// File: rtl/cfg_rd_arbiter.sv
// Round-robin arbiter sharing one per-neuron configuration read port between
// NUM_REQ requesters, with locked bursts and a one-cycle read-valid return.
//
// state       | meaning
// ST_UNLOCKED | round-robin arbitration from ptr_q across all requesters
// ST_LOCKED   | only owner_q may be granted; ptr_q frozen until release
module cfg_rd_arbiter #(
  parameter int NUM_REQ            = 4,
  parameter int NURN_CNT_BIT_WIDTH = 8,
  parameter int MAX_BURST          = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  cfg_rd_arbiter_if.slave  bus
);
  localparam int W     = NURN_CNT_BIT_WIDTH;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] lock_owner_q, lock_owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] rd_vld_q, rd_vld_d;

  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any;
  logic [PTR_W-1:0]   gnt_idx;
  logic [W-1:0]       addr_sel;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] k);
    if (int'(k) == NUM_REQ - 1) return '0;
    else                        return k + PTR_W'(1);
  endfunction

  // pick at most one requester: owner only while locked, else first from ptr_q
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (state_q == ST_LOCKED) begin
      if (bus.req_i[owner_q]) begin
        gnt_any = 1'b1;
        gnt_idx = owner_q;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = int'(ptr_q) + i;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!gnt_any && bus.req_i[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = PTR_W'(idx);
        end
      end
    end
    gnt[gnt_idx] = gnt_any;
    addr_sel     = bus.addr_i[int'(gnt_idx)*W +: W];
  end

  // lock FSM, pointer and burst counter next-state
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    lock_owner_d = lock_owner_q;
    cnt_d        = cnt_q;
    rd_vld_d     = gnt;
    case (state_q)
      ST_UNLOCKED: begin
        if (gnt_any) begin
          ptr_d = wrap_inc(gnt_idx);
          // a one-beat burst limit means the lock expires on the beat that takes it
          if (bus.lock_i[gnt_idx] && (MAX_BURST > 1)) begin
            state_d      = ST_LOCKED;
            owner_d      = gnt_idx;
            lock_owner_d = gnt;
            cnt_d        = CNT_W'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (gnt_any) begin
          if (!bus.lock_i[owner_q] || (int'(cnt_q) + 1 >= MAX_BURST)) begin
            state_d      = ST_UNLOCKED;
            ptr_d        = wrap_inc(owner_q);
            lock_owner_d = '0;
            cnt_d        = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (!bus.lock_i[owner_q]) begin
          // owner idle with lock dropped: abandon the burst
          state_d      = ST_UNLOCKED;
          ptr_d        = wrap_inc(owner_q);
          lock_owner_d = '0;
          cnt_d        = '0;
        end
      end
      default: state_d = ST_UNLOCKED;
    endcase
  end

  // all arbiter state, cleared asynchronously so in-flight valids are dropped
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_UNLOCKED;
      ptr_q        <= '0;
      owner_q      <= '0;
      lock_owner_q <= '0;
      cnt_q        <= '0;
      rd_vld_q     <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      lock_owner_q <= lock_owner_d;
      cnt_q        <= cnt_d;
      rd_vld_q     <= rd_vld_d;
    end
  end

  assign bus.gnt_o         = gnt;
  assign bus.rdEn_Config_o = gnt_any;
  assign bus.Addr_Config_o = gnt_any ? addr_sel : '0;
  assign bus.rdVld_o       = rd_vld_q;
  assign bus.lockOwner_o   = lock_owner_q;

endmodule
